sfr_ta_ctrl: RTL and testbench
==============================

SFR_TA_CTRL -- requirements
Module: sfr_ta_ctrl

Interface
REQ-001 SHALL have parameter WINDOW, default 4, meaning the number of cycles the protected-write window stays open after an unlock.
REQ-002 SHALL have parameter AA_GAP, default 3, meaning the maximum number of cycles allowed from the 0xAA TA write to the 0x55 TA write.
REQ-003 SHALL have parameter PROT_MASK, default OP_DTMCON_WR_BYTE, meaning the op bits that require timed access.
REQ-004 SHALL have parameter TA_ADDR, default 8'hC7, meaning the SFR address of the timed-access register.
REQ-005 SHALL have port i_clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port i_wr, input, 1 bit: CPU SFR write strobe.
REQ-008 SHALL have port i_addr, input, 8 bits: SFR write address.
REQ-009 SHALL have port i_byte, input, 8 bits: SFR write data.
REQ-010 SHALL have port i_op, input, SFR_OP_LEN bits: decoded op bitmask from the SFR decoder.
REQ-011 SHALL have port o_op, output, SFR_OP_LEN bits: gated op bitmask to the SFR registers.
REQ-012 SHALL have port o_byte, output, 8 bits: write data to the SFRs, equal to i_byte.
REQ-013 SHALL have port o_ta_open, output, 1 bit: high while the window is open.
REQ-014 SHALL have port o_blocked, output, 1 bit: one-cycle registered pulse when a protected op was masked.
REQ-015 SHALL have port o_violation, output, 1 bit: sticky violation flag (present only under the macro).

Function
REQ-016 SHALL implement FSM states IDLE, GOT_AA and OPEN.
REQ-017 SHALL move from IDLE to GOT_AA on i_wr with i_addr==TA_ADDR and i_byte==8'hAA.
REQ-018 SHALL move from GOT_AA to OPEN on a TA write of 8'h55 within AA_GAP cycles.
- GOT_AA SHALL return to IDLE on gap expiry or on a TA write of any other value.
- A TA write of 8'hAA in GOT_AA SHALL stay in GOT_AA and restart the gap counter.
REQ-019 SHALL load the OPEN down-counter with WINDOW-1 and return to IDLE when it reaches 0.
REQ-020 SHALL hold o_ta_open high only in OPEN.
REQ-021 SHALL pass op bits outside PROT_MASK combinationally to o_op in the same cycle (zero latency), in every state.
REQ-022 SHALL pass PROT_MASK bits only when the FSM is in OPEN in that cycle; otherwise those bits SHALL be forced to 0.
REQ-023 SHALL close the window after one protected op passes: next state IDLE, so one unlock allows one protected write.
REQ-024 SHALL handle a mixed op (protected and unprotected bits set) outside OPEN by passing the unprotected bits, masking the protected bits and pulsing o_blocked.
REQ-025 SHALL treat a TA write in OPEN as re-arming: the window closes, and a value of 0xAA goes to GOT_AA, any other value to IDLE.
REQ-026 SHALL give a protected op priority when it coincides with the last window cycle (counter==0); the op passes.
REQ-027 SHALL hold o_op at 0 while i_rst_n is low.
REQ-028 SHALL ignore i_op when i_wr is low: o_op=0 and no state change.

Reset
REQ-029 SHALL, on i_rst_n low (asynchronous), set state=IDLE, counters=0, o_ta_open=0, o_blocked=0 and o_violation=0.
REQ-030 SHALL abort an in-progress unlock or open window on reset mid-sequence; after reset, a fresh 0xAA/0x55 sequence is required.

Configuration
REQ-031 SHALL define macro SFR_TA_VIOLATION_EN.
- Defined: o_violation sets on any o_blocked event or any aborted GOT_AA sequence, and clears only on reset.
- Undefined: o_violation is tied to 0 and the flag register is not built.

Structure
REQ-032 SHALL place the FSM state typedef, TA_ADDR, the 0xAA/0x55 key constants and the default PROT_MASK in the shared SFR package, alongside SFR_OP_LEN and the OP_* bit definitions.
REQ-033 SHALL use one sub-module, sfr_ta_timer: a loadable down-counter with zero flag, instantiated twice (gap timer and window timer).

Verification
REQ-034 SHALL cover: TA=AA, then next cycle TA=55, then a DTMCON write of 8'h3C two cycles later -> o_op has the OP_DTMCON_WR_BYTE bit set, o_byte=8'h3C, o_ta_open drops the next cycle.
REQ-035 SHALL cover: a DTMCON write of 8'h3C without unlock -> protected bit of o_op = 0, o_blocked pulses one cycle, o_violation=1 (macro on) / 0 (macro off).
REQ-036 SHALL cover: TA=AA, then 4 idle cycles, then TA=55 -> state IDLE, o_ta_open stays 0.
REQ-037 SHALL cover: unlock, then 4 idle cycles (WINDOW=4), then a protected write -> write blocked, o_blocked=1.
REQ-038 SHALL cover: unlock, then i_rst_n low for one cycle mid-window -> o_ta_open=0 immediately, a subsequent protected write is blocked.
REQ-039 SHALL cover: an unprotected op issued in IDLE, GOT_AA and OPEN -> passed unchanged in the same cycle, with no FSM change.

Source files
------------

// File: rtl/sfr_ta_ctrl_pkg.sv
// Shared SFR definitions: op bitmask layout, timed-access register address,
// unlock key bytes, FSM state encoding and default protected-op mask.
package sfr_ta_ctrl_pkg;

    localparam int SFR_OP_LEN = 8;

    // One-hot op bits produced by the SFR decoder
    localparam logic [SFR_OP_LEN-1:0] OP_ACC_WR         = 8'h01;
    localparam logic [SFR_OP_LEN-1:0] OP_B_WR           = 8'h02;
    localparam logic [SFR_OP_LEN-1:0] OP_DTMCON_WR_BYTE = 8'h04;
    localparam logic [SFR_OP_LEN-1:0] OP_PSW_WR         = 8'h08;
    localparam logic [SFR_OP_LEN-1:0] OP_SP_WR          = 8'h10;

    localparam logic [SFR_OP_LEN-1:0] DEF_PROT_MASK = OP_DTMCON_WR_BYTE;

    localparam logic [7:0] SFR_TA_ADDR = 8'hC7;
    localparam logic [7:0] TA_KEY_AA   = 8'hAA;
    localparam logic [7:0] TA_KEY_55   = 8'h55;

    typedef logic [1:0] ta_state_t;
    localparam ta_state_t ST_IDLE   = 2'd0;
    localparam ta_state_t ST_GOT_AA = 2'd1;
    localparam ta_state_t ST_OPEN   = 2'd2;

endpackage

// File: rtl/sfr_ta_timer.sv
// Loadable down-counter with zero flag; saturates at 0.
module sfr_ta_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; hold at zero once reached
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_zero = (cnt == '0);

endmodule

// File: rtl/sfr_ta_ctrl.sv
// Timed-access gate for protected SFR writes. A 0xAA then 0x55 write to the
// TA register opens a short window in which one protected op may pass.
// Optional macro SFR_TA_VIOLATION_EN builds the sticky o_violation flag.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | locked, protected ops masked
//   GOT_AA  | 0xAA seen, waiting up to AA_GAP cycles for 0x55
//   OPEN    | window open for WINDOW cycles or one protected op
module sfr_ta_ctrl
    import sfr_ta_ctrl_pkg::*;
#(
    parameter int                    WINDOW    = 4,
    parameter int                    AA_GAP    = 3,
    parameter logic [SFR_OP_LEN-1:0] PROT_MASK = DEF_PROT_MASK,
    parameter logic [7:0]            TA_ADDR   = SFR_TA_ADDR
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [7:0]            i_addr,
    input  logic [7:0]            i_byte,
    input  logic [SFR_OP_LEN-1:0] i_op,
    output logic [SFR_OP_LEN-1:0] o_op,
    output logic [7:0]            o_byte,
    output logic                  o_ta_open,
    output logic                  o_blocked,
    output logic                  o_violation
);

    localparam int GAP_W = (AA_GAP > 1) ? $clog2(AA_GAP) : 1;
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    ta_state_t state, state_nxt;
    logic      gap_load, gap_zero;
    logic      win_load, win_zero;
    logic      ta_wr, prot_hit, blocked_now, in_open;

    assign in_open     = (state == ST_OPEN);
    assign ta_wr       = i_wr && (i_addr == TA_ADDR);
    assign prot_hit    = i_wr && ((i_op & PROT_MASK) != '0);
    assign blocked_now = prot_hit && !in_open;

    // Unprotected bits pass straight through; protected bits only in OPEN
    always_comb begin
        o_op = '0;
        if (i_rst_n && i_wr) begin
            o_op = (i_op & ~PROT_MASK) | (in_open ? (i_op & PROT_MASK) : '0);
        end
    end

    assign o_byte    = i_byte;
    assign o_ta_open = in_open;

    // Next-state and timer load decisions
    always_comb begin
        state_nxt = state;
        gap_load  = 1'b0;
        win_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ta_wr && (i_byte == TA_KEY_AA)) begin
                    state_nxt = ST_GOT_AA;
                    gap_load  = 1'b1;
                end
            end
            ST_GOT_AA: begin
                if (ta_wr) begin
                    if (i_byte == TA_KEY_55) begin
                        state_nxt = ST_OPEN;
                        win_load  = 1'b1;
                    end else if (i_byte == TA_KEY_AA) begin
                        gap_load  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (gap_zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OPEN: begin
                // A protected op wins even on the last window cycle
                if (prot_hit) begin
                    state_nxt = ST_IDLE;
                end else if (ta_wr) begin
                    if (i_byte == TA_KEY_AA) begin
                        state_nxt = ST_GOT_AA;
                        gap_load  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (win_zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // One-cycle pulse for every masked protected op
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_blocked <= 1'b0;
        end else begin
            o_blocked <= blocked_now;
        end
    end

    sfr_ta_timer #(.W(GAP_W)) u_gap_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (gap_load),
        .i_load_val (GAP_W'(AA_GAP - 1)),
        .i_en       (state == ST_GOT_AA),
        .o_zero     (gap_zero)
    );

    sfr_ta_timer #(.W(WIN_W)) u_win_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (win_load),
        .i_load_val (WIN_W'(WINDOW - 1)),
        .i_en       (in_open),
        .o_zero     (win_zero)
    );

`ifdef SFR_TA_VIOLATION_EN
    logic abort_now;
    assign abort_now = (state == ST_GOT_AA) && (state_nxt == ST_IDLE);

    // Sticky flag, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_violation <= 1'b0;
        end else if (blocked_now || abort_now) begin
            o_violation <= 1'b1;
        end
    end
`else
    assign o_violation = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_ta_ctrl.sv
// Directed bench for sfr_ta_ctrl with an expectation queue.
module tb_sfr_ta_ctrl;
    import sfr_ta_ctrl_pkg::*;

`ifdef SFR_TA_VIOLATION_EN
    localparam logic VON = 1'b1;
`else
    localparam logic VON = 1'b0;
`endif

    localparam logic [7:0] DTM = 8'hD5;
    localparam logic [7:0] OTH = 8'h80;
    localparam logic [7:0] PRT = OP_DTMCON_WR_BYTE;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_wr = 1'b0;
    logic [7:0] i_addr = 8'h00;
    logic [7:0] i_byte = 8'h00;
    logic [7:0] i_op = 8'h00;
    logic [7:0] o_op, o_byte;
    logic       o_ta_open, o_blocked, o_violation;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] byt;
        logic       open;
        logic       blk;
        logic       viol;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    sfr_ta_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr        (i_wr),
        .i_addr      (i_addr),
        .i_byte      (i_byte),
        .i_op        (i_op),
        .o_op        (o_op),
        .o_byte      (o_byte),
        .o_ta_open   (o_ta_open),
        .o_blocked   (o_blocked),
        .o_violation (o_violation)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle (called at posedge+1), compare at the negedge
    task automatic cyc(input string tag, input logic wr, input logic [7:0] addr,
                       input logic [7:0] byt, input logic [7:0] op,
                       input logic [7:0] e_op, input logic e_open,
                       input logic e_blk, input logic e_viol);
        exp_t e;
        i_wr = wr; i_addr = addr; i_byte = byt; i_op = op;
        q.push_back('{op: e_op, byt: byt, open: e_open, blk: e_blk, viol: e_viol});
        @(negedge i_clk);
        e = q.pop_front();
        chk({tag, ".op"},   o_op, e.op);
        chk({tag, ".byte"}, o_byte, e.byt);
        chk({tag, ".open"}, {7'd0, o_ta_open}, {7'd0, e.open});
        chk({tag, ".blk"},  {7'd0, o_blocked}, {7'd0, e.blk});
        chk({tag, ".viol"}, {7'd0, o_violation}, {7'd0, e.viol});
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic e_open, input logic e_blk, input logic e_viol);
        cyc(tag, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, e_open, e_blk, e_viol);
    endtask

    task automatic ta(input string tag, input logic [7:0] key, input logic e_open,
                      input logic e_blk, input logic e_viol);
        cyc(tag, 1'b1, SFR_TA_ADDR, key, 8'h00, 8'h00, e_open, e_blk, e_viol);
    endtask

    initial begin
        // Reset: outputs quiet, o_op held at 0 even with a write present
        i_wr = 1'b1; i_addr = OTH; i_byte = 8'h11; i_op = OP_ACC_WR | PRT;
        @(negedge i_clk);
        chk("rst.op", o_op, 8'h00);
        chk("rst.open", {7'd0, o_ta_open}, 8'h00);
        chk("rst.blk", {7'd0, o_blocked}, 8'h00);
        chk("rst.viol", {7'd0, o_violation}, 8'h00);
        i_wr = 1'b0; i_op = 8'h00;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Unprotected in IDLE, then unlock and a DTMCON write two cycles later
        cyc("idle_unp", 1'b1, OTH, 8'h11, OP_ACC_WR, OP_ACC_WR, 0, 0, 0);
        ta("u1_aa", TA_KEY_AA, 0, 0, 0);
        ta("u1_55", TA_KEY_55, 0, 0, 0);
        cyc("u1_nowr", 1'b0, DTM, 8'h3C, PRT, 8'h00, 1, 0, 0);
        cyc("u1_dtm", 1'b1, DTM, 8'h3C, PRT, PRT, 1, 0, 0);
        idle("u1_closed", 0, 0, 0);

        // Protected write without unlock, then a mixed op
        cyc("nolock", 1'b1, DTM, 8'h3C, PRT, 8'h00, 0, 0, 0);
        idle("nolock_p", 0, 1, VON);
        idle("nolock_p2", 0, 0, VON);
        cyc("mixed", 1'b1, DTM, 8'h3C, PRT | OP_ACC_WR, OP_ACC_WR, 0, 0, VON);
        idle("mixed_p", 0, 1, VON);

        // 0xAA then 4 idle cycles, 0x55 too late
        ta("gap_aa", TA_KEY_AA, 0, 0, VON);
        for (int i = 0; i < 4; i++) idle("gap_wait", 0, 0, VON);
        ta("gap_55", TA_KEY_55, 0, 0, VON);
        idle("gap_chk", 0, 0, VON);

        // 0x55 exactly AA_GAP cycles after 0xAA, then protected op on last window cycle
        ta("gmax_aa", TA_KEY_AA, 0, 0, VON);
        idle("gmax_w1", 0, 0, VON);
        idle("gmax_w2", 0, 0, VON);
        ta("gmax_55", TA_KEY_55, 0, 0, VON);
        idle("win_c3", 1, 0, VON);
        idle("win_c2", 1, 0, VON);
        idle("win_c1", 1, 0, VON);
        cyc("win_last", 1'b1, DTM, 8'h5A, PRT, PRT, 1, 0, VON);
        idle("win_last_p", 0, 0, VON);

        // Window expires after WINDOW cycles
        ta("exp_aa", TA_KEY_AA, 0, 0, VON);
        ta("exp_55", TA_KEY_55, 0, 0, VON);
        for (int i = 0; i < 4; i++) idle("exp_open", 1, 0, VON);
        cyc("exp_wr", 1'b1, DTM, 8'h3C, PRT, 8'h00, 0, 0, VON);
        idle("exp_p", 0, 1, VON);

        // Unprotected ops in GOT_AA and OPEN do not disturb the sequence
        ta("unp_aa", TA_KEY_AA, 0, 0, VON);
        cyc("unp_gotaa", 1'b1, OTH, 8'h22, OP_B_WR, OP_B_WR, 0, 0, VON);
        ta("unp_55", TA_KEY_55, 0, 0, VON);
        cyc("unp_open", 1'b1, OTH, 8'h33, OP_ACC_WR, OP_ACC_WR, 1, 0, VON);
        idle("unp_still", 1, 0, VON);
        cyc("unp_prot", 1'b1, DTM, 8'h44, PRT, PRT, 1, 0, VON);
        idle("unp_closed", 0, 0, VON);

        // TA write inside OPEN re-arms
        ta("ra_aa", TA_KEY_AA, 0, 0, VON);
        ta("ra_55", TA_KEY_55, 0, 0, VON);
        ta("ra_aa2", TA_KEY_AA, 1, 0, VON);
        ta("ra_55b", TA_KEY_55, 0, 0, VON);
        ta("ra_x12", 8'h12, 1, 0, VON);
        idle("ra_idle", 0, 0, VON);

        // Reset mid-window
        ta("rw_aa", TA_KEY_AA, 0, 0, VON);
        ta("rw_55", TA_KEY_55, 0, 0, VON);
        idle("rw_open", 1, 0, VON);
        i_rst_n = 1'b0;
        #1;
        chk("rw_rst_open", {7'd0, o_ta_open}, 8'h00);
        chk("rw_rst_viol", {7'd0, o_violation}, 8'h00);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        idle("rw_after", 0, 0, 0);
        // Aborted unlock alone sets the violation flag
        ta("ab_aa", TA_KEY_AA, 0, 0, 0);
        ta("ab_bad", 8'h33, 0, 0, 0);
        idle("ab_p", 0, 0, VON);
        cyc("rw_prot", 1'b1, DTM, 8'h3C, PRT, 8'h00, 0, 0, VON);
        idle("rw_prot_p", 0, 1, VON);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
